// File: rtl/fdiv_pkg.sv
// fdiv_pkg
//   Shared constants for the multi-channel clock divider (fdivision_multi).
//   MODE_SQUARE / MODE_PULSE encode the per-channel output mode;
//   DEF_DIV_DEFAULT is the divisor every channel wakes up with after reset
//   (19 -> 20-cycle half-period -> 250 kHz square wave from 10 MHz).
package fdiv_pkg;

  localparam logic MODE_SQUARE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  localparam int DEF_DIV_DEFAULT = 19;

  // Address width for a channel index; never narrower than one bit so a
  // single-channel build still has a legal wr_addr port.
  function automatic int addr_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/fdivision_multi_if.sv
// fdivision_multi_if
//   Register-write bus, run controls and divided outputs of fdivision_multi.
//   Signals:
//     wr_en, wr_addr, wr_div, wr_mode : divisor/mode write to one channel
//     ch_en                          : per-channel level-sensitive run enable
//     sync                           : one-cycle restart of all channels
//     clk_out, tick                  : per-channel divided output and wrap pulse
//   Modports:
//     master : the controller driving writes/enables (e.g. a testbench)
//     slave  : the divider itself
interface fdivision_multi_if
  import fdiv_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 8
);

  localparam int AW = addr_width(NCH);

  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [CW-1:0]  wr_div;
  logic           wr_mode;
  logic [NCH-1:0] ch_en;
  logic           sync;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;

  modport master (
    output wr_en, wr_addr, wr_div, wr_mode, ch_en, sync,
    input  clk_out, tick
  );

  modport slave (
    input  wr_en, wr_addr, wr_div, wr_mode, ch_en, sync,
    output clk_out, tick
  );

endinterface

// File: rtl/fdiv_channel.sv
// fdiv_channel
//   One divider channel: counter, shadow/active divisor and mode, and the
//   registered output/tick. The shadow registers take writes at any time;
//   the active copies only follow them at a period boundary (wrap) or while
//   the channel is idle (disabled or being synced), so the output never
//   sees a truncated or stretched period.
//   Ports:
//     clk      : system clock, rising edge
//     RESET    : synchronous, active-low reset
//     en       : channel run enable (already combined with the enable reg)
//     sync     : restart request, phase-aligns with the other channels
//     ld       : load ld_div/ld_mode into the shadow registers
//     ld_div   : new divisor
//     ld_mode  : new mode (MODE_SQUARE / MODE_PULSE)
//     out      : divided output
//     tick     : one-cycle pulse on each counter wrap
module fdiv_channel
  import fdiv_pkg::*;
#(
  parameter int            CW      = 8,
  parameter logic [CW-1:0] DEF_DIV = CW'(DEF_DIV_DEFAULT)
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic          en,
  input  logic          sync,
  input  logic          ld,
  input  logic [CW-1:0] ld_div,
  input  logic          ld_mode,
  output logic          out,
  output logic          tick
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] act_div;
  logic [CW-1:0] sh_div;
  logic          act_mode;
  logic          sh_mode;

  logic [CW-1:0] nxt_div;
  logic          nxt_mode;
  logic          wrap;

  // Value the active registers pick up when they are allowed to change.
  // A write landing in the same cycle bypasses the shadow so it is not
  // delayed by a whole extra period.
  always_comb begin
    nxt_div  = sh_div;
    nxt_mode = sh_mode;
    if (ld) begin
      nxt_div  = ld_div;
      nxt_mode = ld_mode;
    end
  end

  // Equality compare is enough: act_div only moves while cnt is 0 (or is
  // being cleared), so the counter can never be above it.
  assign wrap = (cnt == act_div);

  // Priority inside the run logic: disable > sync > wrap > count.
  always_ff @(posedge clk) begin
    if (!RESET) begin
      cnt      <= '0;
      out      <= 1'b0;
      tick     <= 1'b0;
      act_div  <= DEF_DIV;
      sh_div   <= DEF_DIV;
      act_mode <= MODE_SQUARE;
      sh_mode  <= MODE_SQUARE;
    end else begin
      if (ld) begin
        sh_div  <= ld_div;
        sh_mode <= ld_mode;
      end

      if (!en || sync) begin
        cnt      <= '0;
        out      <= 1'b0;
        tick     <= 1'b0;
        act_div  <= nxt_div;
        act_mode <= nxt_mode;
      end else if (wrap) begin
        cnt      <= '0;
        tick     <= 1'b1;
        act_div  <= nxt_div;
        act_mode <= nxt_mode;
        // The output rule for this edge follows the mode being entered:
        // pulse strobes high, square-from-pulse starts low, and
        // square-to-square toggles as usual.
        if (nxt_mode == MODE_PULSE) begin
          out <= 1'b1;
        end else if (act_mode == MODE_PULSE) begin
          out <= 1'b0;
        end else begin
          out <= ~out;
        end
      end else begin
        cnt  <= cnt + 1'b1;
        tick <= 1'b0;
        if (act_mode == MODE_PULSE) begin
          out <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/fdivision_multi.sv
// fdivision_multi
//   Multi-channel programmable clock-enable / divider generator running
//   from the 10 MHz system clock. Each of NCH channels has its own divisor
//   and square/pulse mode, written through the bus interface and applied
//   glitch-free at the channel's next period boundary. A common sync
//   input restarts every enabled channel in phase.
//   Ports:
//     F10M   : 10 MHz system clock, rising edge
//     RESET  : synchronous, active-low reset
//     bus    : fdivision_multi_if.slave (write bus, ch_en, sync,
//              clk_out, tick)
module fdivision_multi
  import fdiv_pkg::*;
#(
  parameter int             NCH     = 4,
  parameter int             CW      = 8,
  parameter int             DEF_DIV = DEF_DIV_DEFAULT,
  parameter logic [NCH-1:0] DEF_EN  = '1
) (
  input  logic               F10M,
  input  logic               RESET,
  fdivision_multi_if.slave   bus
);

  localparam int AW = addr_width(NCH);

  logic [NCH-1:0] en_reg;
  logic [NCH-1:0] run_en;
  logic [NCH-1:0] ld;

  // Internal enable register. It has no write path yet, so it simply
  // holds its reset value; it is kept as a register so a later control
  // port can program it without touching the channels.
  always_ff @(posedge F10M) begin
    if (!RESET) begin
      en_reg <= DEF_EN;
    end
  end

  assign run_en = en_reg & bus.ch_en;

  // Address decode. Addresses at or above NCH match no channel, so such
  // writes fall through without effect.
  always_comb begin
    ld = '0;
    for (int i = 0; i < NCH; i++) begin
      ld[i] = bus.wr_en && (bus.wr_addr == AW'(i));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    fdiv_channel #(
      .CW      (CW),
      .DEF_DIV (CW'(DEF_DIV))
    ) u_ch (
      .clk     (F10M),
      .RESET   (RESET),
      .en      (run_en[g]),
      .sync    (bus.sync),
      .ld      (ld[g]),
      .ld_div  (bus.wr_div),
      .ld_mode (bus.wr_mode),
      .out     (bus.clk_out[g]),
      .tick    (bus.tick[g])
    );
  end

endmodule

// File: tb/tb_fdivision_multi.sv
// tb_fdivision_multi
//   Directed testbench for fdivision_multi (NCH=4, CW=8, DEF_DIV=19).
//   Time is counted in rising edges since the last reset edge (t=0 is the
//   state right after reset, t=n after n run edges). Outputs are sampled
//   1 time unit after each rising edge.
module tb_fdivision_multi;

  localparam int NCH = 4;
  localparam int CW  = 8;

  logic clk;
  logic rst_n;
  int   t;
  int   checks;
  int   errors;

  fdivision_multi_if #(.NCH(NCH), .CW(CW)) bus ();

  fdivision_multi #(
    .NCH     (NCH),
    .CW      (CW),
    .DEF_DIV (19),
    .DEF_EN  (4'b1111)
  ) dut (
    .F10M  (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  typedef struct {
    int       cyc;
    logic [3:0] exp_out;
    logic [3:0] exp_tick;
  } vec_t;

  vec_t tbl[8];

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic run_to(input int target);
    while (t < target) step();
  endtask

  task automatic applyStimulus(input logic en, input logic [1:0] addr,
                               input logic [CW-1:0] div, input logic mode,
                               input logic [NCH-1:0] chen, input logic syn);
    bus.wr_en   = en;
    bus.wr_addr = addr;
    bus.wr_div  = div;
    bus.wr_mode = mode;
    bus.ch_en   = chen;
    bus.sync    = syn;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] exp_out,
                             input logic [3:0] exp_tick);
    checks++;
    if (bus.clk_out !== exp_out || bus.tick !== exp_tick) begin
      errors++;
      $display("[TB] FAIL %s t=%0d: clk_out=%b tick=%b, expected clk_out=%b tick=%b",
               name, t, bus.clk_out, bus.tick, exp_out, exp_tick);
    end
  endtask

  task automatic do_reset();
    applyStimulus(1'b0, 2'd0, '0, 1'b0, 4'b1111, 1'b0);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    t = 0;
  endtask

  task automatic write_ch(input logic [1:0] ch, input logic [CW-1:0] div,
                          input logic mode);
    applyStimulus(1'b1, ch, div, mode, 4'b1111, 1'b0);
    step();
    applyStimulus(1'b0, 2'd0, '0, 1'b0, 4'b1111, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    t      = 0;
    rst_n  = 1'b0;
    applyStimulus(1'b0, 2'd0, '0, 1'b0, 4'b1111, 1'b0);

    // Default run: toggle every 20 edges, tick with each toggle.
    tbl[0] = '{0,  4'b0000, 4'b0000};
    tbl[1] = '{19, 4'b0000, 4'b0000};
    tbl[2] = '{20, 4'b1111, 4'b1111};
    tbl[3] = '{21, 4'b1111, 4'b0000};
    tbl[4] = '{39, 4'b1111, 4'b0000};
    tbl[5] = '{40, 4'b0000, 4'b1111};
    tbl[6] = '{59, 4'b0000, 4'b0000};
    tbl[7] = '{60, 4'b1111, 4'b1111};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      run_to(tbl[i].cyc);
      checkOutput($sformatf("default_t%0d", tbl[i].cyc), tbl[i].exp_out, tbl[i].exp_tick);
    end

    // ch1 div=4 written mid-period: takes effect at the wrap at t=60.
    do_reset();
    run_to(44);
    write_ch(2'd1, 8'd4, 1'b0);
    run_to(59); checkOutput("div4_t59", 4'b0000, 4'b0000);
    run_to(60); checkOutput("div4_t60", 4'b1111, 4'b1111);
    run_to(64); checkOutput("div4_t64", 4'b1111, 4'b0000);
    run_to(65); checkOutput("div4_t65", 4'b1101, 4'b0010);
    run_to(70); checkOutput("div4_t70", 4'b1111, 4'b0010);
    run_to(75); checkOutput("div4_t75", 4'b1101, 4'b0010);
    run_to(80); checkOutput("div4_t80", 4'b0010, 4'b1111);

    // ch2 pulse mode div=9 from the wrap at t=40, then div=0 from t=70.
    do_reset();
    run_to(29);
    write_ch(2'd2, 8'd9, 1'b1);
    run_to(40); checkOutput("pulse_t40", 4'b0100, 4'b1111);
    run_to(41); checkOutput("pulse_t41", 4'b0000, 4'b0000);
    run_to(49); checkOutput("pulse_t49", 4'b0000, 4'b0000);
    run_to(50); checkOutput("pulse_t50", 4'b0100, 4'b0100);
    run_to(51); checkOutput("pulse_t51", 4'b0000, 4'b0000);
    run_to(60); checkOutput("pulse_t60", 4'b1111, 4'b1111);
    write_ch(2'd2, 8'd0, 1'b1);
    run_to(69); checkOutput("pdiv0_t69", 4'b1011, 4'b0000);
    run_to(70); checkOutput("pdiv0_t70", 4'b1111, 4'b0100);
    run_to(71); checkOutput("pdiv0_t71", 4'b1111, 4'b0100);
    run_to(75); checkOutput("pdiv0_t75", 4'b1111, 4'b0100);
    run_to(80); checkOutput("pdiv0_t80", 4'b0100, 4'b1111);

    // ch0 div=2, ch3 div=6, then sync at edge t=31.
    do_reset();
    write_ch(2'd0, 8'd2, 1'b0);
    write_ch(2'd3, 8'd6, 1'b0);
    run_to(30);
    applyStimulus(1'b0, 2'd0, '0, 1'b0, 4'b1111, 1'b1);
    step();
    applyStimulus(1'b0, 2'd0, '0, 1'b0, 4'b1111, 1'b0);
    checkOutput("sync_t31", 4'b0000, 4'b0000);
    run_to(33); checkOutput("sync_t33", 4'b0000, 4'b0000);
    run_to(34); checkOutput("sync_t34", 4'b0001, 4'b0001);
    run_to(37); checkOutput("sync_t37", 4'b0000, 4'b0001);
    run_to(38); checkOutput("sync_t38", 4'b1000, 4'b1000);
    run_to(40); checkOutput("sync_t40", 4'b1001, 4'b0001);

    // ch_en[1] low for edges 26..32, re-enabled from edge 33.
    do_reset();
    run_to(25);
    applyStimulus(1'b0, 2'd0, '0, 1'b0, 4'b1101, 1'b0);
    step();
    checkOutput("dis_t26", 4'b1101, 4'b0000);
    run_to(32); checkOutput("dis_t32", 4'b1101, 4'b0000);
    applyStimulus(1'b0, 2'd0, '0, 1'b0, 4'b1111, 1'b0);
    run_to(40); checkOutput("dis_t40", 4'b0000, 4'b1101);
    run_to(51); checkOutput("dis_t51", 4'b0000, 4'b0000);
    run_to(52); checkOutput("dis_t52", 4'b0010, 4'b0010);

    // Reset mid-run with a write and sync pending: reset wins, write lost.
    do_reset();
    write_ch(2'd1, 8'd4, 1'b0);
    run_to(22);
    checkOutput("prerst_t22", 4'b1111, 4'b0000);
    rst_n = 1'b0;
    applyStimulus(1'b1, 2'd0, 8'd3, 1'b1, 4'b1111, 1'b1);
    step();
    checkOutput("rst_pri", 4'b0000, 4'b0000);
    applyStimulus(1'b0, 2'd0, '0, 1'b0, 4'b1111, 1'b0);
    rst_n = 1'b1;
    t = 0;
    run_to(4);  checkOutput("rst_t4", 4'b0000, 4'b0000);
    run_to(5);  checkOutput("rst_t5", 4'b0000, 4'b0000);
    run_to(19); checkOutput("rst_t19", 4'b0000, 4'b0000);
    run_to(20); checkOutput("rst_t20", 4'b1111, 4'b1111);
    run_to(21); checkOutput("rst_t21", 4'b1111, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
